// File: rtl/counter_bank_pkg.sv
// ============================================================================
// Module  : counter_bank_pkg
// Brief   : Shared arithmetic-mode constants and select-width helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package counter_bank_pkg;

    localparam int c_MODE_WRAP = 0;
    localparam int c_MODE_SAT  = 1;

    // Smallest select width able to address n channels (never below 1).
    function automatic int sel_width_for(input int n);
        int w;
        w = 1;
        for (int k = 1; k < 31; k++) begin
            if ((1 << w) < n) w = k + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_bank_channel.sv
// ============================================================================
// Module  : counter_bank_channel
// Brief   : One counter with sticky over/underflow flag and update priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module counter_bank_channel
    import counter_bank_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SATURATE    = c_MODE_WRAP,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    input  logic             rdclr_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] c_RST = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] c_MAX = '1;
    localparam logic             c_SAT = (SATURATE == c_MODE_SAT);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] w_base, w_next;
    logic             w_base_ovf, w_hit;

    always_comb begin
        w_base     = cnt_q;
        w_base_ovf = ovf_q;
        w_hit      = 1'b0;
        // Read-clear restarts from RESET_VALUE so this cycle's strobe still counts.
        if (rdclr_i) begin
            w_base     = c_RST;
            w_base_ovf = 1'b0;
        end
        w_next = w_base;
        if (inc_i && !dec_i) begin
            if (w_base == c_MAX) begin
                w_hit  = 1'b1;
                w_next = c_SAT ? c_MAX : '0;
            end else begin
                w_next = w_base + WIDTH'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (w_base == '0) begin
                w_hit  = 1'b1;
                w_next = c_SAT ? '0 : c_MAX;
            end else begin
                w_next = w_base - WIDTH'(1);
            end
        end
        if (clr_i) begin
            cnt_d = c_RST;
            ovf_d = 1'b0;
        end else begin
            cnt_d = w_next;
            ovf_d = w_base_ovf | w_hit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= c_RST;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/counter_bank.sv
// ============================================================================
// Module  : counter_bank
// Brief   : Bank of event counters with registered indexed read/clear port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int SATURATE     = c_MODE_WRAP,
    parameter int SEL_WIDTH    = 2,
    parameter int RESET_VALUE  = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CHANNELS-1:0] inc_i,
    input  logic [NUM_CHANNELS-1:0] dec_i,
    input  logic [NUM_CHANNELS-1:0] clr_i,
    input  logic                    rd_valid_i,
    input  logic [SEL_WIDTH-1:0]    rd_sel_i,
    input  logic                    rd_clr_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic                    rd_valid_o,
    output logic [NUM_CHANNELS-1:0] ovf_o
);

    generate
        if (WIDTH < 1 || NUM_CHANNELS < 1 || SEL_WIDTH < sel_width_for(NUM_CHANNELS)) begin : g_param_error
            $error("counter_bank: illegal WIDTH/NUM_CHANNELS/SEL_WIDTH");
        end
    endgenerate

    logic [NUM_CHANNELS-1:0][WIDTH-1:0] w_cnt;
    logic [NUM_CHANNELS-1:0]            w_rdclr;
    logic                               w_sel_ok;
    logic [WIDTH-1:0]                   w_rd_value;
    logic [WIDTH-1:0]                   rd_data_q;
    logic                               rd_valid_q;

    assign w_sel_ok = (32'(rd_sel_i) < NUM_CHANNELS);

    generate
        for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
            assign w_rdclr[i] = rd_valid_i & rd_clr_i & w_sel_ok
                              & (rd_sel_i == SEL_WIDTH'(i));

            counter_bank_channel #(
                .WIDTH       (WIDTH),
                .SATURATE    (SATURATE),
                .RESET_VALUE (RESET_VALUE)
            ) u_channel (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .inc_i   (inc_i[i]),
                .dec_i   (dec_i[i]),
                .clr_i   (clr_i[i]),
                .rdclr_i (w_rdclr[i]),
                .cnt_o   (w_cnt[i]),
                .ovf_o   (ovf_o[i])
            );
        end
    endgenerate

    // Out-of-range selects fall through to zero.
    always_comb begin
        w_rd_value = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_sel_ok && rd_sel_i == SEL_WIDTH'(i)) w_rd_value = w_cnt[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_i;
            if (rd_valid_i) rd_data_q <= w_rd_value;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_bank.sv
// ============================================================================
// Module  : tb_counter_bank
// Brief   : Scoreboard bench for a wrapping and a saturating 4x4-bit bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_counter_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] inc = '0, dec = '0, clr = '0;
    logic       rv  = 1'b0, rc = 1'b0;
    logic [2:0] sel = '0;

    logic [3:0] data_w, data_s, ovf_w, ovf_s;
    logic       vld_w, vld_s;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit       v;
        int       data;
        bit [3:0] ovf;
    } exp_t;

    exp_t q_w[$];
    exp_t q_s[$];

    // Reference state: [0] = wrap bank (reset 0), [1] = saturating bank (reset 3)
    int mcnt [2][4];
    bit movf [2][4];
    int mlast[2];
    int msat [2] = '{0, 1};
    int mrv  [2] = '{0, 3};

    always #5 clk = ~clk;

    counter_bank #(.WIDTH(4), .NUM_CHANNELS(4), .SATURATE(0), .SEL_WIDTH(3), .RESET_VALUE(0)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .inc_i(inc), .dec_i(dec), .clr_i(clr),
        .rd_valid_i(rv), .rd_sel_i(sel), .rd_clr_i(rc),
        .rd_data_o(data_w), .rd_valid_o(vld_w), .ovf_o(ovf_w));

    counter_bank #(.WIDTH(4), .NUM_CHANNELS(4), .SATURATE(1), .SEL_WIDTH(3), .RESET_VALUE(3)) dut_sat (
        .clk_i(clk), .rst_i(rst), .inc_i(inc), .dec_i(dec), .clr_i(clr),
        .rd_valid_i(rv), .rd_sel_i(sel), .rd_clr_i(rc),
        .rd_data_o(data_s), .rd_valid_o(vld_s), .ovf_o(ovf_s));

    task automatic model(input int d);
        exp_t e;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                mcnt[d][c] = mrv[d];
                movf[d][c] = 1'b0;
            end
            mlast[d] = 0;
            e.v = 1'b0;
        end else begin
            e.v = rv;
            if (rv) mlast[d] = (sel < 4) ? mcnt[d][sel] : 0;
            for (int c = 0; c < 4; c++) begin
                int  b;
                bit  o;
                int  step;
                if (clr[c]) begin
                    mcnt[d][c] = mrv[d];
                    movf[d][c] = 1'b0;
                end else begin
                    b = mcnt[d][c];
                    o = movf[d][c];
                    if (rv && rc && sel == c) begin
                        b = mrv[d];
                        o = 1'b0;
                    end
                    step = int'(inc[c]) - int'(dec[c]);
                    if (step == 1) begin
                        if (b == 15) begin o = 1'b1; b = msat[d] ? 15 : 0; end
                        else b = b + 1;
                    end else if (step == -1) begin
                        if (b == 0) begin o = 1'b1; b = msat[d] ? 0 : 15; end
                        else b = b - 1;
                    end
                    mcnt[d][c] = b;
                    movf[d][c] = o;
                end
            end
        end
        e.data = mlast[d];
        for (int c = 0; c < 4; c++) e.ovf[c] = movf[d][c];
        if (d == 0) q_w.push_back(e);
        else        q_s.push_back(e);
    endtask

    task automatic cyc(input logic [3:0] i_inc, input logic [3:0] i_dec, input logic [3:0] i_clr,
                       input logic i_rv, input logic [2:0] i_sel, input logic i_rc, input logic i_rst);
        @(negedge clk);
        inc = i_inc; dec = i_dec; clr = i_clr;
        rv = i_rv; sel = i_sel; rc = i_rc; rst = i_rst;
        model(0);
        model(1);
    endtask

    task automatic compare(input string name, input exp_t e, input logic v,
                           input logic [3:0] data, input logic [3:0] ovf);
        checks += 3;
        if (v !== e.v) begin
            failures++;
            $display("FAIL %s rd_valid_o got=%b want=%b t=%0t", name, v, e.v, $time);
        end
        if (int'(data) != e.data || $isunknown(data)) begin
            failures++;
            $display("FAIL %s rd_data_o got=%0d want=%0d t=%0t", name, data, e.data, $time);
        end
        if (ovf !== 4'(e.ovf)) begin
            failures++;
            $display("FAIL %s ovf_o got=%b want=%b t=%0t", name, ovf, e.ovf, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_w.size() > 0) begin
                e = q_w.pop_front();
                compare("wrap", e, vld_w, data_w, ovf_w);
            end
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                compare("sat", e, vld_s, data_s, ovf_s);
            end
        end
    end

    initial begin
        cyc(4'h0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1);
        cyc(4'h0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(4'h0, 4'h0, 4'h0, 1'b1, 3'(i), 1'b0, 1'b0);
        // Full-range increment on channel 1, then read it back
        repeat (16) cyc(4'b0010, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc(4'h0, 4'h0, 4'h0, 1'b1, 3'd1, 1'b0, 1'b0);
        repeat (4) cyc(4'h0, 4'b1000, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc(4'h0, 4'h0, 4'h0, 1'b1, 3'd3, 1'b0, 1'b0);
        cyc(4'b0001, 4'b0001, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc(4'h0, 4'h0, 4'h0, 1'b1, 3'd0, 1'b0, 1'b0);
        // Channel 2 to a known value, then inc concurrent with read-clear
        cyc(4'h0, 4'h0, 4'b0100, 1'b0, 3'd0, 1'b0, 1'b0);
        repeat (5) cyc(4'b0100, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc(4'b0100, 4'h0, 4'h0, 1'b1, 3'd2, 1'b1, 1'b0);
        cyc(4'h0, 4'h0, 4'h0, 1'b1, 3'd2, 1'b0, 1'b0);
        repeat (4) cyc(4'h0, 4'b0001, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc(4'b0001, 4'h0, 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc(4'h0, 4'h0, 4'h0, 1'b1, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(4'h0, 4'h0, 4'h0, 1'b1, 3'(i), 1'b0, 1'b0);
        cyc(4'h0, 4'h0, 4'h0, 1'b1, 3'd5, 1'b1, 1'b0);
        cyc(4'h0, 4'h0, 4'h0, 1'b1, 3'd1, 1'b0, 1'b1);
        cyc(4'h0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        repeat (600) begin
            cyc(4'($urandom), 4'($urandom),
                ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'h0,
                1'($urandom), 3'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
        end
        repeat (3) cyc(4'h0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q_w.size() != 0 || q_s.size() != 0) begin
            failures++;
            $display("FAIL drain queue sizes got=%0d/%0d want=0/0", q_w.size(), q_s.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
